// File: rtl/reg_bank_pkg.sv
// Shared types, default sizes and the round-robin pick helper for reg_bank_ctrl.
package reg_bank_pkg;

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_N_REGS = 8;
  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned MAX_REQ    = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  // Lowest valid index at or above ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ({29'd0, ptr} + k) % n;
      if (k < n && !found && valid[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/reg_bank_ctrl_rr_arbiter.sv
// Combinational round-robin winner select; the pointer register lives in the caller.
module rr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             any_valid
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         ptr_ext;
  logic [2:0]         pick;

  // Widen to the helper's fixed width, pick, and narrow back.
  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = valid;
    ptr_ext                = '0;
    ptr_ext[IW-1:0]        = ptr;
    pick                   = rr_pick(valid_ext, ptr_ext, N_REQ);
    winner                 = pick[IW-1:0];
    any_valid              = |valid;
  end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Sole writer of a shared register bank: round-robin write arbitration,
// sequenced bulk clear and a registered read port.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned N_REGS = DEF_N_REGS,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  localparam int unsigned AW    = $clog2(N_REGS),
  localparam int unsigned GW    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   clr_start,
  output logic                   clr_done,
  output logic                   busy,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [GW-1:0]          grant_id
);

  state_t           state, state_next;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    win;
  logic             any_valid;
  logic [AW-1:0]    clr_cnt;
  logic             clr_pending;
  logic             clr_go;
  logic             clr_last;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] bank [N_REGS];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .winner    (win),
    .any_valid (any_valid)
  );

  // Decode helpers: clear request, last clear step, winner's write port.
  always_comb begin
    clr_go   = clr_pending | clr_start;
    clr_last = (clr_cnt == AW'(N_REGS - 1));
    wr_addr  = req_addr[int'(grant_id)*AW +: AW];
    wr_data  = req_data[int'(grant_id)*WIDTH +: WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: clear beats writes; WRITE lasts one cycle; CLEAR walks the bank.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_go) state_next = CLEAR;
               else if (any_valid) state_next = WRITE;
      WRITE:   state_next = IDLE;
      CLEAR:   if (clr_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    req_ready = '0;
    if (state == WRITE) req_ready[grant_id] = 1'b1;
    clr_done  = (state == CLEAR) && clr_last;
    busy      = (state != IDLE);
  end

  // Arbitration pointer, grant latch, clear sequencing and pending-clear flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      clr_cnt     <= '0;
      clr_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_go) begin
            clr_cnt     <= '0;
            clr_pending <= 1'b0;
          end else if (any_valid) begin
            grant_id <= win;
          end
        end
        WRITE: begin
          rr_ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          if (clr_start) clr_pending <= 1'b1;
        end
        CLEAR:   clr_cnt <= clr_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Bank storage and registered read; a same-cycle write is seen on the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) bank[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= bank[rd_addr];
      if (state == WRITE)      bank[wr_addr] <= wr_data;
      else if (state == CLEAR) bank[clr_cnt] <= '0;
    end
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: transaction model plus directed vectors.
module tb_reg_bank_ctrl;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int W  = 32;
  localparam int AW = 3;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0]  req_data = '0;
  logic [N-1:0]    req_ready;
  logic            clr_start = 1'b0;
  logic            clr_done;
  logic            busy;
  logic [AW-1:0]   rd_addr = '0;
  logic [W-1:0]    rd_data;
  logic [GW-1:0]   grant_id;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_bank_ctrl #(.N_REQ(N), .N_REGS(R), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .clr_done  (clr_done),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .grant_id  (grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: mode 0 = idle, 1 = writing for m_gid, 2 = clearing slot m_cnt.
  int          m_mode = 0;
  int          m_cnt  = 0;
  int          m_ptr  = 0;
  int          m_gid  = 0;
  int          m_j;
  bit          m_pend = 0;
  bit          m_found;
  logic [W-1:0] m_mem [R] = '{default: '0};
  logic [W-1:0] m_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_ptr = 0; m_gid = 0; m_pend = 0; m_rd = '0;
      for (int i = 0; i < R; i++) m_mem[i] = '0;
    end else begin
      m_rd = m_mem[rd_addr];
      if (m_mode == 0) begin
        if (m_pend || clr_start) begin
          m_mode = 2; m_cnt = 0; m_pend = 0;
        end else if (req_valid != '0) begin
          m_found = 0;
          for (int k = 0; k < N; k++) begin
            m_j = (m_ptr + k) % N;
            if (!m_found && req_valid[m_j]) begin m_gid = m_j; m_found = 1; end
          end
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        m_mem[req_addr[m_gid*AW +: AW]] = req_data[m_gid*W +: W];
        m_ptr  = (m_gid + 1) % N;
        m_mode = 0;
        if (clr_start) m_pend = 1;
      end else begin
        m_mem[m_cnt] = '0;
        if (m_cnt == R - 1) m_mode = 0;
        else m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy",      busy,      (m_mode != 0));
      chk("req_ready", req_ready, (m_mode == 1) ? (32'd1 << m_gid) : 32'd0);
      chk("clr_done",  clr_done,  (m_mode == 2) && (m_cnt == R - 1));
      chk("grant_id",  grant_id,  m_gid);
      chk("rd_data",   rd_data,   m_rd);
    end
  end

  // Handshake rule: a requester must keep valid up until the edge that commits it.
  logic [N-1:0] rdy_q  = '0;
  logic [N-1:0] p_pend = '0;
  always @(negedge clk) rdy_q = req_ready;
  always @(posedge clk or posedge rst) begin
    if (rst) p_pend = '0;
    else begin
      for (int i = 0; i < N; i++) begin
        if (p_pend[i] && !req_valid[i]) begin
          n_total++;
          $display("FAIL handshake: requester %0d dropped valid before ready at %0t", i, $time);
        end
        p_pend[i] = req_valid[i] && !rdy_q[i];
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*W +: W]    = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    clr_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_one(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    bit seen;
    seen = 0;
    set_req(i, 1'b1, a, d);
    for (int k = 0; k < 12 && !seen; k++) begin
      cyc();
      if (req_ready[i]) seen = 1;
    end
    chk("write_ready_seen", seen, 1);
    cyc();
    req_valid[i] = 1'b0;
  endtask

  logic [3:0] t2_exp [10] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
  int ndone;
  int rdy_at;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, single write, read-during-write returns old value
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_rd", rd_data, 0);
    set_req(0, 1'b1, 3'd3, 32'hDEADBEEF);
    rd_addr = 3'd3;
    cyc();
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_gid", grant_id, 0);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_rd_old", rd_data, 0);
    chk("t1_ready_off", req_ready, 0);
    req_valid[0] = 1'b0;
    cyc();
    chk("t1_rd_new", rd_data, 32'hDEADBEEF);

    // 2: round-robin fairness with all requesters held valid
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(4 + i), 32'h2000_0000 + i);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t2_ready_seq", req_ready, t2_exp[k]);
    end

    // 3: pointer wraps from 3 back to 0
    do_reset();
    set_req(3, 1'b1, 3'd1, 32'hA3A3_0003);
    cyc();
    chk("t3_ready3", req_ready, 4'b1000);
    chk("t3_gid3", grant_id, 3);
    cyc();
    set_req(3, 1'b1, 3'd5, 32'hB3B3_0003);
    set_req(0, 1'b1, 3'd2, 32'hA0A0_0000);
    cyc();
    chk("t3_ready0", req_ready, 4'b0001);
    chk("t3_gid0", grant_id, 0);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    chk("t3_ready3b", req_ready, 4'b1000);
    cyc();
    req_valid[3] = 1'b0;

    // 4: bulk clear with a request waiting behind it
    do_reset();
    for (int a = 0; a < R; a++) write_one(1, 3'(a), 32'h4000_0010 + a);
    clr_start = 1'b1;
    set_req(1, 1'b1, 3'd6, 32'h5555_AAAA);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1) clr_start = 1'b0;
      chk("t4_busy", busy, 1);
      chk("t4_no_ready", req_ready, 0);
      chk("t4_done", clr_done, (k == 8));
    end
    cyc();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready", req_ready, 0);
    cyc();
    chk("t4_late_ready", req_ready, 4'b0010);
    cyc();
    req_valid[1] = 1'b0;
    for (int a = 0; a < R; a++) begin
      rd_addr = 3'(a);
      cyc();
      chk("t4_readback", rd_data, (a == 6) ? 32'h5555_AAAA : 32'h0);
    end

    // 5: clear and request together, second clear pulse merged
    do_reset();
    clr_start = 1'b1;
    set_req(2, 1'b1, 3'd3, 32'hC2C2_0002);
    ndone  = 0;
    rdy_at = -1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (k == 1) clr_start = 1'b0;
      if (k == 3) clr_start = 1'b1;
      if (k == 4) clr_start = 1'b0;
      if (clr_done) ndone++;
      if (req_ready[2] && rdy_at < 0) rdy_at = k;
      if (k == 11) req_valid[2] = 1'b0;
    end
    chk("t5_done_once", ndone, 1);
    chk("t5_ready_cycle", rdy_at, 10);
    chk("t5_idle", busy, 0);

    // 6: asynchronous reset in the middle of a clear
    do_reset();
    write_one(1, 3'd7, 32'h7777_0007);
    rd_addr   = 3'd7;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk("t6_pre_rd", rd_data, 32'h7777_0007);
    chk("t6_pre_gid", grant_id, 1);
    chk("t6_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", req_ready, 0);
    chk("t6_async_done", clr_done, 0);
    chk("t6_async_gid", grant_id, 0);
    chk("t6_async_rd", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < R; a++) begin
      rd_addr = 3'(a);
      cyc();
      chk("t6_readback", rd_data, 0);
    end
    set_req(0, 1'b1, 3'd2, 32'h0F0F_0000);
    set_req(3, 1'b1, 3'd4, 32'h0F0F_0003);
    cyc();
    chk("t6_first_grant", req_ready, 4'b0001);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    chk("t6_second_grant", req_ready, 4'b1000);
    cyc();
    req_valid[3] = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
